blit_scheduler: RTL and testbench

BLIT_SCHEDULER -- requirements
Module: blit_scheduler

---
 rtl/blit_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_blit_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_scheduler.sv
// rtl/blit_scheduler.sv - frame-synchronised sprite blitter: command FIFO, ROM address walk, pixel write port
module blit_scheduler (
  input  logic        clk,
  input  logic        iReset,
  input  logic        iVSync,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  input  logic [8:0]  iCmdX,
  input  logic [7:0]  iCmdY,
  input  logic [4:0]  iCmdW,
  input  logic [4:0]  iCmdH,
  input  logic [3:0]  iCmdSel,
  input  logic [16:0] iCmdBase,
  input  logic        iCmdKey,
  output logic [16:0] oRomAddr,
  output logic [3:0]  oRomSel,
  input  logic [2:0]  iRomQ,
  output logic [8:0]  oX,
  output logic [7:0]  oY,
  output logic [2:0]  oColor,
  output logic        oWriteEn,
  output logic        oBusy,
  output logic        oFrameDone,
  output logic        oOverrun
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, FLUSH} state_t;

  typedef struct packed {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [4:0]  w;
    logic [4:0]  h;
    logic [3:0]  sel;
    logic [16:0] base;
    logic        key;
  } cmd_t;

  state_t      state, state_next;
  cmd_t        fifo_mem [8];
  cmd_t        cmd_in, head;
  logic [2:0]  wr_ptr, rd_ptr;
  logic [3:0]  count;
  logic        push, pop;

  logic        vsync_q, fall;
  logic [3:0]  frame_cnt;
  logic [8:0]  cur_x;
  logic [7:0]  cur_y;
  logic [4:0]  cur_w, cur_h, col, row;
  logic [3:0]  cur_sel;
  logic        cur_key;
  logic [16:0] addr;
  logic        last_pix;
  logic [9:0]  x_sum;
  logic [8:0]  y_sum;

  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic        pix_on, pix_key;
  logic        frame_done, overrun;

  assign cmd_in    = {iCmdX, iCmdY, iCmdW, iCmdH, iCmdSel, iCmdBase, iCmdKey};
  assign head      = fifo_mem[rd_ptr];
  assign oCmdReady = (count != 4'd8);
  assign push      = iCmdValid && oCmdReady;
  assign pop       = (state == LOAD);
  assign fall      = vsync_q && !iVSync;
  assign last_pix  = (col == cur_w) && (row == cur_h);
  // Widened sums so sprites hanging off the right/bottom edge clip instead of wrapping.
  assign x_sum     = {1'b0, cur_x} + {5'b0, col};
  assign y_sum     = {1'b0, cur_y} + {4'b0, row};

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (iReset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (fall && count != 4'd0) state_next = LOAD;
      LOAD:  state_next = DRAW;
      DRAW:  if (last_pix) state_next = (frame_cnt != 4'd1) ? LOAD : FLUSH;
      FLUSH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      vsync_q    <= 1'b0;
      frame_cnt  <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      cur_w      <= '0;
      cur_h      <= '0;
      cur_sel    <= '0;
      cur_key    <= 1'b0;
      col        <= '0;
      row        <= '0;
      addr       <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      vsync_q    <= iVSync;
      frame_done <= (state == FLUSH) || (state == IDLE && fall && count == 4'd0);
      overrun    <= fall && (state != IDLE);
      case (state)
        IDLE: if (fall && count != 4'd0) frame_cnt <= count;
        LOAD: begin
          cur_x   <= head.x;
          cur_y   <= head.y;
          cur_w   <= head.w;
          cur_h   <= head.h;
          cur_sel <= head.sel;
          cur_key <= head.key;
          addr    <= head.base;
          col     <= '0;
          row     <= '0;
        end
        DRAW: begin
          addr <= addr + 17'd1;
          if (col == cur_w) begin
            col <= '0;
            row <= row + 5'd1;
            if (row == cur_h) frame_cnt <= frame_cnt - 4'd1;
          end else begin
            col <= col + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel stage lines up with the ROM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (iReset) begin
      pix_x   <= '0;
      pix_y   <= '0;
      pix_on  <= 1'b0;
      pix_key <= 1'b0;
    end else begin
      pix_x   <= x_sum[8:0];
      pix_y   <= y_sum[7:0];
      pix_on  <= (state == DRAW) && (x_sum <= 10'd319) && (y_sum <= 9'd239);
      pix_key <= cur_key;
    end
  end

  assign oRomAddr   = addr;
  assign oRomSel    = cur_sel;
  assign oX         = pix_x;
  assign oY         = pix_y;
  assign oColor     = iRomQ;
  assign oWriteEn   = pix_on && !(pix_key && iRomQ == 3'b101);
  assign oBusy      = (state != IDLE);
  assign oFrameDone = frame_done;
  assign oOverrun   = overrun;

endmodule

// File: tb/tb_blit_scheduler.sv
// tb/tb_blit_scheduler.sv - scoreboard bench for blit_scheduler with a queue-based frame model
module tb_blit_scheduler;

  logic        clk = 1'b0;
  logic        iReset, iVSync, iCmdValid, oCmdReady;
  logic [8:0]  iCmdX;
  logic [7:0]  iCmdY;
  logic [4:0]  iCmdW, iCmdH;
  logic [3:0]  iCmdSel;
  logic [16:0] iCmdBase;
  logic        iCmdKey;
  logic [16:0] oRomAddr;
  logic [3:0]  oRomSel;
  logic [2:0]  iRomQ;
  logic [8:0]  oX;
  logic [7:0]  oY;
  logic [2:0]  oColor;
  logic        oWriteEn, oBusy, oFrameDone, oOverrun;

  always #5 clk = ~clk;

  blit_scheduler dut (
    .clk(clk), .iReset(iReset), .iVSync(iVSync), .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
    .iCmdX(iCmdX), .iCmdY(iCmdY), .iCmdW(iCmdW), .iCmdH(iCmdH), .iCmdSel(iCmdSel),
    .iCmdBase(iCmdBase), .iCmdKey(iCmdKey), .oRomAddr(oRomAddr), .oRomSel(oRomSel),
    .iRomQ(iRomQ), .oX(oX), .oY(oY), .oColor(oColor), .oWriteEn(oWriteEn),
    .oBusy(oBusy), .oFrameDone(oFrameDone), .oOverrun(oOverrun)
  );

  typedef struct { int x, y, w, h, sel, base, key; } cmd_s;
  typedef struct { int x, y, c; } wr_s;

  cmd_s pending[$];
  wr_s  exp_q[$];
  int   len_q[$];
  int   n_checks = 0, n_fail = 0;
  int   n_writes = 0, n_done = 0, n_ovr = 0, exp_done = 0, exp_ovr = 0;
  int   run = 0;
  bit   in_frame = 0, abort = 0;

  // Sprite ROM: sel 10 returns the key colour on every odd address.
  function automatic logic [2:0] rom_f(input logic [16:0] a, input logic [3:0] s);
    if (s == 4'hA) return a[0] ? 3'b101 : 3'b010;
    return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9] ^ a[14:12] ^ {1'b0, a[16:15]} ^ s[2:0];
  endfunction

  always @(posedge clk) iRomQ <= rom_f(oRomAddr, oRomSel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic cmd_s mk(input int x, y, w, h, sel, base, key);
    cmd_s c;
    c.x = x; c.y = y; c.w = w; c.h = h; c.sel = sel; c.base = base; c.key = key;
    return c;
  endfunction

  always @(negedge clk) begin
    wr_s w;
    if (oWriteEn === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        w = exp_q.pop_front();
        chk("wr_x", 32'(oX), w.x);
        chk("wr_y", 32'(oY), w.y);
        chk("wr_color", 32'(oColor), w.c);
      end
    end
    if (oBusy === 1'b1) run++;
    else if (run > 0) begin
      if (len_q.size() == 0) chk("busy_unexpected", 1, 0);
      else if (abort) begin
        void'(len_q.pop_front());
        chk("abort_no_done", 32'(oFrameDone), 0);
        abort = 0;
      end else begin
        chk("busy_len", run, len_q.pop_front());
        chk("done_at_busy_drop", 32'(oFrameDone), 1);
      end
      run = 0;
    end
    if (oFrameDone === 1'b1) n_done++;
    if (oOverrun === 1'b1) n_ovr++;
  end

  // Expand the snapshotted commands into the writes and busy length a frame must produce.
  task automatic model_frame();
    int len, a, x, y, c;
    exp_done++;
    if (pending.size() == 0) return;
    len = 1;
    foreach (pending[i]) begin
      for (int r = 0; r <= pending[i].h; r++)
        for (int k = 0; k <= pending[i].w; k++) begin
          a = pending[i].base + r * (pending[i].w + 1) + k;
          x = pending[i].x + k;
          y = pending[i].y + r;
          c = int'(rom_f(17'(a), 4'(pending[i].sel)));
          if (x <= 319 && y <= 239 && !(pending[i].key != 0 && c == 5))
            exp_q.push_back('{x: x, y: y, c: c});
        end
      len += 1 + (pending[i].w + 1) * (pending[i].h + 1);
    end
    len_q.push_back(len);
    in_frame = 1;
    pending.delete();
  endtask

  task automatic push(input cmd_s c, input bit check_ready);
    logic rdy;
    @(negedge clk);
    iCmdValid = 1'b1;
    iCmdX = 9'(c.x); iCmdY = 8'(c.y); iCmdW = 5'(c.w); iCmdH = 5'(c.h);
    iCmdSel = 4'(c.sel); iCmdBase = 17'(c.base); iCmdKey = 1'(c.key);
    rdy = oCmdReady;
    if (check_ready) chk("cmd_ready", 32'(rdy), (pending.size() < 8) ? 1 : 0);
    if (rdy) pending.push_back(c);
    @(posedge clk);
    #1 iCmdValid = 1'b0;
  endtask

  task automatic vsync_fall();
    @(negedge clk) iVSync = 1'b1;
    @(negedge clk);
    @(negedge clk) iVSync = 1'b0;
    if (in_frame) exp_ovr++;
    else model_frame();
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (oFrameDone === 1'b1) break;
    end
    chk("frame_done_seen", (i < 4000) ? 1 : 0, 1);
    chk("writes_drained", exp_q.size(), 0);
    in_frame = 0;
  endtask

  initial begin
    int w0;
    iReset = 1'b1; iVSync = 1'b0; iCmdValid = 1'b0;
    iCmdX = '0; iCmdY = '0; iCmdW = '0; iCmdH = '0; iCmdSel = '0; iCmdBase = '0; iCmdKey = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(oBusy), 0);
    chk("rst_we", 32'(oWriteEn), 0);
    chk("rst_done", 32'(oFrameDone), 0);
    chk("rst_ovr", 32'(oOverrun), 0);
    chk("rst_ready", 32'(oCmdReady), 1);
    chk("rst_addr", 32'(oRomAddr), 0);
    iReset = 1'b0;

    w0 = n_writes;
    push(mk(120, 155, 17, 17, 0, 0, 0), 1);
    vsync_fall();
    wait_done();
    chk("single_writes", n_writes - w0, 324);

    w0 = n_writes;
    for (int i = 0; i < 4; i++) push(mk(120 + 17 * i, 10, 17, 17, i, 1000 * i, 0), 1);
    vsync_fall();
    wait_done();
    chk("four_writes", n_writes - w0, 1296);

    w0 = n_writes;
    push(mk(318, 238, 3, 3, 0, 0, 0), 1);
    vsync_fall();
    wait_done();
    chk("clip_writes", n_writes - w0, 4);

    w0 = n_writes;
    push(mk(10, 10, 7, 1, 10, 0, 1), 1);
    vsync_fall();
    wait_done();
    chk("key_writes", n_writes - w0, 8);
    w0 = n_writes;
    push(mk(10, 10, 7, 1, 10, 0, 0), 1);
    vsync_fall();
    wait_done();
    chk("nokey_writes", n_writes - w0, 16);

    for (int i = 0; i < 9; i++) push(mk(20 * i, 20, 3, 3, i, 100 * i, 0), 1);
    vsync_fall();
    repeat (20) @(negedge clk);
    push(mk(400, 200, 3, 3, 5, 77, 1), 0);
    vsync_fall();
    wait_done();
    chk("overrun_count", n_ovr, 1);
    vsync_fall();
    wait_done();

    for (int f = 0; f < 4; f++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++)
        push(mk($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 131071),
                $urandom_range(0, 1)), 1);
      vsync_fall();
      wait_done();
    end

    push(mk(0, 0, 31, 31, 3, 500, 0), 1);
    vsync_fall();
    repeat (50) @(negedge clk);
    abort = 1;
    iReset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    pending.delete();
    in_frame = 0;
    exp_done--;
    w0 = n_writes;
    @(negedge clk);
    chk("abort_we", 32'(oWriteEn), 0);
    chk("abort_busy", 32'(oBusy), 0);
    chk("abort_ready", 32'(oCmdReady), 1);
    iReset = 1'b0;
    repeat (5) @(negedge clk);
    vsync_fall();
    wait_done();
    chk("abort_no_writes", n_writes - w0, 0);

    repeat (3) @(negedge clk);
    chk("done_count", n_done, exp_done);
    chk("overrun_total", n_ovr, exp_ovr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
